// File: rtl/lpacc_if.sv
// Beat/result handshake bundle between lpmul, the lpacc accumulator stage and its consumer.
interface lpacc_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_prod;
  logic        in_sign;
  logic        in_sat;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_ovf;

  modport slave (
    input  in_valid, in_prod, in_sign, in_sat, in_last, out_ready,
    output in_ready, out_valid, out_res, out_ovf
  );

  modport master (
    output in_valid, in_prod, in_sign, in_sat, in_last, out_ready,
    input  in_ready, out_valid, out_res, out_ovf
  );
endinterface

// File: rtl/lpacc.sv
// Low-precision accumulator: sums a group of 16-bit products and returns one
// clamped (sat) or truncated (non-sat) 16-bit result per group.
module lpacc #(
  parameter int MAX_BEATS = 16,
  parameter int ACC_W     = 20
) (
  input  logic   clk,
  input  logic   rst,
  lpacc_if.slave bus
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] S_P127   = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] S_N128   = ACC_W'(-128);
  localparam logic signed [ACC_W-1:0] S_P32767 = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] S_N32768 = ACC_W'(-32768);
  localparam logic        [ACC_W-1:0] U_255    = ACC_W'(255);
  localparam logic        [ACC_W-1:0] U_65535  = ACC_W'(65535);
  localparam logic        [4:0]       CNT_LAST = 5'(MAX_BEATS);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               mode_sign_q, mode_sign_d;
  logic               mode_sat_q, mode_sat_d;
  logic [15:0]        res_q, res_d;
  logic               ovf_q, ovf_d;

  logic               accept;
  logic               first;
  logic               sign_eff;
  logic               sat_eff;
  logic               close;
  logic [ACC_W-1:0]   ext;
  logic [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0] sum_s;
  logic [15:0]        res_c;
  logic               ovf_c;

  // The first beat of a group uses its own mode bits; later beats use the latched ones.
  always_comb begin
    accept   = bus.in_valid && (state_q == S_ACC);
    first    = (cnt_q == '0);
    sign_eff = first ? bus.in_sign : mode_sign_q;
    sat_eff  = first ? bus.in_sat  : mode_sat_q;
    ext      = sign_eff ? {{(ACC_W-16){bus.in_prod[15]}}, bus.in_prod}
                        : {{(ACC_W-16){1'b0}}, bus.in_prod};
    sum      = first ? ext : acc_q + ext;
    sum_s    = $signed(sum);
    close    = accept && (bus.in_last || ((cnt_q + 5'd1) == CNT_LAST));
  end

  always_comb begin
    res_c = sum[15:0];
    ovf_c = 1'b0;
    if (sat_eff && sign_eff) begin
      if (sum_s > S_P127) begin
        res_c = 16'h007F;
        ovf_c = 1'b1;
      end else if (sum_s < S_N128) begin
        res_c = 16'hFF80;
        ovf_c = 1'b1;
      end
    end else if (sat_eff) begin
      if (sum > U_255) begin
        res_c = 16'h00FF;
        ovf_c = 1'b1;
      end
    end else if (sign_eff) begin
      ovf_c = (sum_s > S_P32767) || (sum_s < S_N32768);
    end else begin
      ovf_c = (sum > U_65535);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mode_sign_d = mode_sign_q;
    mode_sat_d  = mode_sat_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_ACC: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + 5'd1;
          if (first) begin
            mode_sign_d = bus.in_sign;
            mode_sat_d  = bus.in_sat;
          end
          if (close) begin
            cnt_d   = '0;
            res_d   = res_c;
            ovf_d   = ovf_c;
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      mode_sign_q <= 1'b0;
      mode_sat_q  <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mode_sign_q <= mode_sign_d;
      mode_sat_q  <= mode_sat_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == S_ACC);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_res   = res_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_lpacc.sv
// Self-checking bench for lpacc: directed scenarios plus randomized groups
// checked against an integer-arithmetic reference model.
module tb_lpacc;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lpacc_if bus();

  lpacc #(.MAX_BEATS(MAXB), .ACC_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q_prod[$];
  logic        q_sign[$];
  logic        q_sat[$];

  task automatic clear_q();
    q_prod.delete();
    q_sign.delete();
    q_sat.delete();
  endtask

  task automatic add_beat(input logic [15:0] p, input logic s, input logic t);
    q_prod.push_back(p);
    q_sign.push_back(s);
    q_sat.push_back(t);
  endtask

  // Mode comes from the first beat; sum is exact integer arithmetic.
  function automatic void model(output logic [15:0] r, output logic o);
    longint s;
    logic sg, st;
    sg = q_sign[0];
    st = q_sat[0];
    s  = 0;
    foreach (q_prod[i]) begin
      if (sg) s += longint'($signed(q_prod[i]));
      else    s += longint'(q_prod[i]);
    end
    r = 16'(s);
    o = 1'b0;
    if (st && sg) begin
      if (s > 127)       begin r = 16'h007F; o = 1'b1; end
      else if (s < -128) begin r = 16'hFF80; o = 1'b1; end
    end else if (st) begin
      if (s > 255) begin r = 16'h00FF; o = 1'b1; end
    end else if (sg) begin
      o = (s > 32767) || (s < -32768);
    end else begin
      o = (s > 65535);
    end
  endfunction

  task automatic run_group(input bit use_last, input string name);
    logic [15:0] er;
    logic        eo;
    int          waited;
    model(er, eo);
    foreach (q_prod[i]) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_prod  = q_prod[i];
      bus.in_sign  = q_sign[i];
      bus.in_sat   = q_sat[i];
      bus.in_last  = use_last && (i == q_prod.size() - 1);
      waited = 0;
      while (!bus.in_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_ready_timeout: in_ready stayed %b, required 1", name, bus.in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: out_valid=%b, required 1", name, bus.out_valid);
    end
    n_tests++;
    if (bus.out_res !== er) begin
      n_fail++;
      $display("FAIL %s_res: out_res=%h, required %h", name, bus.out_res, er);
    end
    n_tests++;
    if (bus.out_ovf !== eo) begin
      n_fail++;
      $display("FAIL %s_ovf: out_ovf=%b, required %b", name, bus.out_ovf, eo);
    end
    if (bus.out_ready) begin
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_one_cycle: out_valid=%b, required 0", name, bus.out_valid);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'h1234;
    bus.in_last  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst = 1'b0;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid);
    end
    n_tests++;
    if (bus.out_res !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_out_res: got %h, required 0000", bus.out_res);
    end
    n_tests++;
    if (bus.out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_ovf: got %b, required 0", bus.out_ovf);
    end
  endtask

  task automatic test_signed_nonsat();
    clear_q();
    add_beat(16'hFFF6, 1'b1, 1'b0);
    add_beat(16'h0014, 1'b1, 1'b0);
    add_beat(16'hFFFB, 1'b1, 1'b0);
    run_group(1'b1, "signed_nonsat");
  endtask

  task automatic test_signed_sat();
    clear_q();
    add_beat(16'h007F, 1'b1, 1'b1);
    add_beat(16'h007F, 1'b1, 1'b1);
    run_group(1'b1, "signed_sat_pos");
    clear_q();
    add_beat(16'hFF80, 1'b1, 1'b1);
    add_beat(16'hFF80, 1'b1, 1'b1);
    run_group(1'b1, "signed_sat_neg");
  endtask

  task automatic test_forced_close();
    clear_q();
    for (int i = 0; i < MAXB; i++) add_beat(16'hFFFF, 1'b0, 1'b0);
    run_group(1'b0, "forced_nonsat");
    clear_q();
    for (int i = 0; i < MAXB; i++) add_beat(16'hFFFF, 1'b0, 1'b1);
    run_group(1'b0, "forced_sat");
  endtask

  task automatic test_mode_latch();
    clear_q();
    add_beat(16'h00F0, 1'b0, 1'b0);
    add_beat(16'h0020, 1'b1, 1'b1);
    run_group(1'b1, "mode_latch");
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    clear_q();
    add_beat(16'h0100, 1'b1, 1'b0);
    add_beat(16'h0023, 1'b1, 1'b0);
    run_group(1'b1, "bp_group");
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'h0042;
    bus.in_sign  = 1'b0;
    bus.in_sat   = 1'b0;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_res !== 16'h0123 || bus.out_ovf !== 1'b0
          || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%b res=%h ovf=%b in_ready=%b, required 1 0123 0 0",
                 bus.out_valid, bus.out_res, bus.out_ovf, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_res !== 16'h0042) begin
      n_fail++;
      $display("FAIL bp_next_beat: valid=%b res=%h, required 1 0042", bus.out_valid, bus.out_res);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'h1234;
    bus.in_sign  = 1'b0;
    bus.in_sat   = 1'b0;
    bus.in_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_prod  = 16'h0F00;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mid_idle: valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
    end
    clear_q();
    add_beat(16'h0003, 1'b0, 1'b0);
    run_group(1'b1, "reset_mid_new");
  endtask

  task automatic test_random();
    int len;
    bit ul;
    logic [15:0] p;
    for (int g = 0; g < 40; g++) begin
      clear_q();
      len = $urandom_range(1, MAXB);
      ul  = (len < MAXB) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: p = 16'($urandom);
          1: p = 16'($urandom_range(0, 255));
          2: p = 16'hFF00 | 16'($urandom_range(0, 255));
          default: begin
            case ($urandom_range(0, 2))
              0: p = 16'hFFFF;
              1: p = 16'h8000;
              default: p = 16'h7FFF;
            endcase
          end
        endcase
        add_beat(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      run_group(ul, "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_sign   = 1'b0;
    bus.in_sat    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_signed_nonsat();
    test_signed_sat();
    test_forced_close();
    test_mode_latch();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpacc.md
# lpacc

Low-precision accumulator stage placed directly downstream of the SPARROW 8-bit multiplier. It takes the 16-bit `high_prec_component` products from `lpmul` one beat at a time over a valid/ready handshake. It sums a group of beats (a dot-product lane) in a 20-bit accumulator. It returns one 16-bit result per group, applying the same sign and saturation semantics as the multiplier: 8-bit clamp when saturating, 16-bit wrap otherwise.

## Interface
- `MAX_BEATS`, default 16: maximum products per group. The beat at count `MAX_BEATS` closes the group even without `in_last`. Legal range is 2..16.
- `ACC_W`, default 20: accumulator width. Must be ≥ 16 + clog2(`MAX_BEATS`).
- `clk` — in — 1 — single clock. All state changes on the rising edge.
- `rst` — in — 1 — reset. Synchronous, active-high.
- `in_valid` — in — 1 — product beat valid.
- `in_ready` — out — 1 — stage can accept a beat.
- `in_prod` — in — 16 — product (`high_prec_component`) from the multiplier.
- `in_sign` — in — 1 — signed mode (same meaning as the multiplier `sign`).
- `in_sat` — in — 1 — saturating mode (same meaning as the multiplier `sat`).
- `in_last` — in — 1 — final beat of the group.
- `out_valid` — out — 1 — result valid.
- `out_ready` — in — 1 — consumer accepts the result.
- `out_res` — out — 16 — group result (`high_prec_component`).
- `out_ovf` — out — 1 — result was clamped (sat) or truncated (non-sat).

## Operation
- FSM states:
  - `S_ACC`: accepting beats. `in_ready`=1.
  - `S_OUT`: holding the result. `in_ready`=0, `out_valid`=1.
- A beat is accepted on a cycle where `in_valid && in_ready`.
- First beat of a group (`cnt`=0):
  - Latch `in_sign` and `in_sat` into `mode_sign` and `mode_sat`.
  - Load `acc` = ext(`in_prod`).
- Later beats: `acc` = `acc` + ext(`in_prod`). Their `in_sign` and `in_sat` are ignored.
- ext(): sign-extend to `ACC_W` when `mode_sign`=1, zero-extend otherwise. On the first beat, ext() uses `in_sign` directly.
- `cnt` (5 bits) increments on every accepted beat.
- The group closes when the accepted beat has `in_last`=1, or when `cnt`+1 == `MAX_BEATS`. On close:
  - Compute `out_res` and `out_ovf` from the final sum (including the closing beat).
  - Register them, clear `cnt`, and go to `S_OUT`.
- Result rules, where S is the final `acc`:
  - sat, signed: S > 127 gives 0x007F; S < −128 gives 0xFF80; otherwise S[15:0]. `out_ovf` = clamp applied.
  - sat, unsigned: S > 255 gives 0x00FF; otherwise S[15:0]. `out_ovf` = clamp applied.
  - non-sat, signed: S[15:0]. `out_ovf` = S outside [−32768, 32767].
  - non-sat, unsigned: S[15:0]. `out_ovf` = S > 65535.
- `S_OUT` to `S_ACC` when `out_valid && out_ready`. `out_res` and `out_ovf` stay stable until then.
- Back-to-back groups: no beat is accepted in the handshake cycle that leaves `S_OUT`, because `in_ready` is still 0. The first beat of the next group is accepted the following cycle at the earliest.
- `in_valid` with `in_ready`=0 has no effect. The upstream must hold its beat.

## Timing
- Reset (`rst`=1 at an edge) sets:
  - state = `S_ACC`, `cnt`=0, `acc`=0, `mode_sign`=0, `mode_sat`=0.
  - `in_ready`=1, `out_valid`=0, `out_res`=0x0000, `out_ovf`=0.
- Reset mid-group or during `S_OUT` discards the partial sum or pending result. No result is emitted.
- Reset has priority over any handshake in the same cycle.
- Latency: closing beat accepted at edge N gives `out_valid`=1 from N (visible in cycle N+1).
- Throughput: a G-beat group occupies G cycles + 1 result cycle minimum.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `out_ready`. `in_ready` = (state == `S_ACC`).
- A single-beat group (`in_last` on the first beat) is legal. The result is the saturated or truncated `in_prod` under the new mode.

## Test plan
- Signed non-sat, 3 beats: 0xFFF6, 0x0014, 0xFFFB(last), `out_ready`=1 → one cycle after the last beat, `out_res`=0x0005, `out_ovf`=0. `out_valid` is high for exactly one cycle.
- Signed sat, group A: 0x007F, 0x007F(last) → `out_res`=0x007F, `out_ovf`=1. Group B: 0xFF80, 0xFF80(last) → `out_res`=0xFF80, `out_ovf`=1.
- Unsigned, 16 beats of 0xFFFF with no `in_last`, non-sat → forced close on beat 16, `out_res`=0xFFF0, `out_ovf`=1. Repeat with sat=1 → 0x00FF, `out_ovf`=1.
- Mode latch: first beat 0x00F0 with sign=0, sat=0; second beat 0x0020(last) with sign=1, sat=1 → unsigned non-sat result 0x0110, `out_ovf`=0.
- Backpressure: result ready with `out_ready`=0 for 3 cycles → `out_valid`, `out_res` and `out_ovf` stable and `in_ready`=0 throughout. No beat accepted until the cycle after `out_ready`=1.
- Reset mid-group: 2 beats accepted, then `rst`=1 for 1 cycle, then new group 0x0003(last) unsigned → `out_res`=0x0003. No output appears for the aborted group.
